fp_add_sub_sign: RTL and testbench

Sign-resolution front end of the floating-point adder. Takes two IEEE-754 single-precision operands and determines which has the larger magnitude (swap select), captures the operand signs, and derives the effective operation (true add vs. true subtract) and the final result sign. Sits ahead of the alignment and mantissa add/subtract datapath, which consumes `sel`, `sel2` and `sign`. The block always computes `num1 + num2`; subtraction is performed upstream by flipping `num2[31]`.

---
 rtl/fp_add_sub_sign_if.sv | 22 ++
 rtl/fp_add_sub_sign.sv | 75 +++++++
 tb/tb_fp_add_sub_sign.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/fp_add_sub_sign_if.sv
// Operand/result bundle for the FP adder sign-resolution front end.
interface fp_add_sub_sign_if;
  logic [31:0] num1;
  logic [31:0] num2;
  logic        sel;
  logic        sign1;
  logic        sign2;
  logic        sel2;
  logic        sign;

  // Producer of operands / consumer of sign decisions
  modport master (
    output num1, num2,
    input  sel, sign1, sign2, sel2, sign
  );

  // Sign-resolution block
  modport slave (
    input  num1, num2,
    output sel, sign1, sign2, sel2, sign
  );
endinterface

// File: rtl/fp_add_sub_sign.sv
// Sign-resolution front end of the FP adder: magnitude compare (swap select),
// operand sign capture, effective operation and result sign.
// Build option: define FP_SIGN_REG_EN to register sel2/sign (2-cycle latency);
// otherwise they are combinational from stage 1 (1-cycle latency).
module fp_add_sub_sign (
  input  logic             clk,
  input  logic             rstn,
  fp_add_sub_sign_if.slave bus
);
  localparam int unsigned MagW = 31;

  logic sel_q, sign1_q, sign2_q, eq_q;
  logic sel_d, eq_d;
  logic sel2_d, sign_d;

  // Stage 1 next state: raw 31-bit magnitude compare (exponent then fraction)
  always_comb begin
    sel_d = 1'b0;
    eq_d  = 1'b0;
    sel_d = (bus.num2[MagW-1:0] >  bus.num1[MagW-1:0]);
    eq_d  = (bus.num2[MagW-1:0] == bus.num1[MagW-1:0]);
  end

  // Stage 1 registers, sampled every cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sel_q   <= 1'b0;
      sign1_q <= 1'b0;
      sign2_q <= 1'b0;
      eq_q    <= 1'b0;
    end else begin
      sel_q   <= sel_d;
      sign1_q <= bus.num1[31];
      sign2_q <= bus.num2[31];
      eq_q    <= eq_d;
    end
  end

  // Stage 2: effective op and result sign; exact cancellation gives +0
  always_comb begin
    sel2_d = 1'b0;
    sign_d = 1'b0;
    sel2_d = sign1_q ^ sign2_q;
    sign_d = sel_q ? sign2_q : sign1_q;
    if (eq_q && sel2_d) begin
      sign_d = 1'b0;
    end
  end

  assign bus.sel   = sel_q;
  assign bus.sign1 = sign1_q;
  assign bus.sign2 = sign2_q;

`ifdef FP_SIGN_REG_EN
  logic sel2_q, sign_q;

  // Stage 2 registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sel2_q <= 1'b0;
      sign_q <= 1'b0;
    end else begin
      sel2_q <= sel2_d;
      sign_q <= sign_d;
    end
  end

  assign bus.sel2 = sel2_q;
  assign bus.sign = sign_q;
`else
  assign bus.sel2 = sel2_d;
  assign bus.sign = sign_d;
`endif

endmodule

// File: tb/tb_fp_add_sub_sign.sv
// Directed-vector bench for fp_add_sub_sign (works with or without FP_SIGN_REG_EN).
module tb_fp_add_sub_sign;
`ifdef FP_SIGN_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int NV = 14;

  typedef struct {
    logic [31:0] num1;
    logic [31:0] num2;
    logic        sel;
    logic        sign1;
    logic        sign2;
    logic        sel2;
    logic        sign;
  } vec_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vec [NV];

  fp_add_sub_sign_if bus ();

  fp_add_sub_sign dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " sel"},   bus.sel,   1'b0);
    chk({tag, " sign1"}, bus.sign1, 1'b0);
    chk({tag, " sign2"}, bus.sign2, 1'b0);
    chk({tag, " sel2"},  bus.sel2,  1'b0);
    chk({tag, " sign"},  bus.sign,  1'b0);
  endtask

  initial begin
    // {num1, num2, sel, sign1, sign2, sel2, sign}
    vec[0]  = '{32'd30,        32'd10,        1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[1]  = '{32'h18000000,  32'h95000000,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vec[2]  = '{32'h98000000,  32'h15000000,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vec[3]  = '{32'h95000100,  32'h15000200,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vec[4]  = '{32'h95000200,  32'h15000100,  1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vec[5]  = '{32'hC2280000,  32'h42280000,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vec[6]  = '{32'h80000000,  32'h80000000,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vec[7]  = '{32'h00000000,  32'h80000000,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vec[8]  = '{32'hBF800000,  32'hBF800000,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vec[9]  = '{32'h3F800000,  32'hC0000000,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    vec[10] = '{32'h7F800000,  32'hFFC00000,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    vec[11] = '{32'h3F800000,  32'h40000000,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[12] = '{32'hC0400000,  32'hBF800000,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vec[13] = '{32'h40490FDB,  32'hC0490FDB,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    // Reset held 20 ns with zero operands
    bus.num1 = 32'h0;
    bus.num2 = 32'h0;
    rstn     = 1'b0;
    #20;
    chk_zero("reset_hold");
    @(negedge clk);
    rstn = 1'b1;

    // One vector at a time, held for two edges so both latencies settle
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      bus.num1 = vec[i].num1;
      bus.num2 = vec[i].num2;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d sel", i),   bus.sel,   vec[i].sel);
      chk($sformatf("v%0d sign1", i), bus.sign1, vec[i].sign1);
      chk($sformatf("v%0d sign2", i), bus.sign2, vec[i].sign2);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d sel2", i),  bus.sel2,  vec[i].sel2);
      chk($sformatf("v%0d sign", i),  bus.sign,  vec[i].sign);
    end

    // Back-to-back stream: new operands every cycle
    for (int k = 0; k < NV + LAT - 1; k++) begin
      @(negedge clk);
      if (k < NV) begin
        bus.num1 = vec[k].num1;
        bus.num2 = vec[k].num2;
      end
      @(posedge clk);
      #1;
      if (k < NV) begin
        chk($sformatf("pipe%0d sel", k),   bus.sel,   vec[k].sel);
        chk($sformatf("pipe%0d sign1", k), bus.sign1, vec[k].sign1);
        chk($sformatf("pipe%0d sign2", k), bus.sign2, vec[k].sign2);
      end
      if (k >= LAT - 1) begin
        chk($sformatf("pipe%0d sel2", k - (LAT - 1)), bus.sel2, vec[k-(LAT-1)].sel2);
        chk($sformatf("pipe%0d sign", k - (LAT - 1)), bus.sign, vec[k-(LAT-1)].sign);
      end
    end

    // Mid-stream async reset: load -0 + -0, then reset between edges
    @(negedge clk);
    bus.num1 = 32'h80000000;
    bus.num2 = 32'h80000000;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("pre_reset sign", bus.sign, 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    chk_zero("async_reset");
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("release sign1", bus.sign1, 1'b1);
    chk("release sign2", bus.sign2, 1'b1);
    chk("release sign",  bus.sign,  (LAT == 1) ? 1'b1 : 1'b0);
    @(posedge clk);
    #1;
    chk("release2 sign", bus.sign, 1'b1);
    chk("release2 sel2", bus.sel2, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
